// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: stall vector layout, request encodings and MDU FSM states.
`timescale 1ns/1ps
package pipe_stall_ctrl_pkg;
  localparam int STALL_W = 6;
  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;
  localparam int STALL_EX = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB = 5;
  localparam logic [STALL_W-1:0] STALL_REQ_LU = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_REQ_MDU = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_REQ_MEM = 6'b011111;
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;
  // Highest stalled stage wins: MEM wait > MDU > load-use.
  function automatic logic [STALL_W-1:0] merge_stall(input logic mem_w, input logic mdu, input logic lu);
    return mem_w ? STALL_REQ_MEM : mdu ? STALL_REQ_MDU : lu ? STALL_REQ_LU : '0;
  endfunction
endpackage

// File: rtl/pipe_stall_ctrl_mdu_cycle_fsm.sv
// mdu_cycle_fsm: IDLE/BUSY/DONE sequencer and down-counter for multi-cycle MDU ops.
`timescale 1ns/1ps
module mdu_cycle_fsm
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic start_i,
  input  logic mem_wait_i,
  output logic mdu_stall_o,
  output logic busy_o,
  output logic done_o
);
  // The IDLE start cycle already stalls, so BUSY covers the remaining MDU_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 2);
  mdu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = MDU_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MDU_IDLE: if (start_i) begin
          state_d = MDU_BUSY;
          cnt_d   = CNT_LOAD;
        end
        MDU_BUSY: if (cnt_q == '0) state_d = MDU_DONE;
                  else cnt_d = cnt_q - CNT_W'(1);
        MDU_DONE: if (!mem_wait_i) state_d = MDU_IDLE;
        default:  state_d = MDU_IDLE;
      endcase
    end
  end
  always_comb begin
    mdu_stall_o = (state_q == MDU_BUSY) || (state_q == MDU_IDLE && start_i);
    busy_o      = state_q == MDU_BUSY;
    done_o      = state_q == MDU_DONE && !flush_i;
  end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges load-use, MDU and MEM-wait requests into the 6-bit stall vector.
// STALL_PERF_CNT_EN adds saturating per-cause stall counters; otherwise perf ports read 0.
`timescale 1ns/1ps
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              id_loaduse_i,
  input  logic              ex_mdu_start_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic [5:0]        stall_o,
  output logic              mdu_busy_o,
  output logic              mdu_done_o,
  output logic [PERF_W-1:0] perf_lu_o,
  output logic [PERF_W-1:0] perf_mdu_o,
  output logic [PERF_W-1:0] perf_mem_o
);
  logic mem_wait, mdu_stall, live;
  assign mem_wait = mem_req_i && !mem_ack_i;
  assign live = rst && !flush_i;
  mdu_cycle_fsm #(.MDU_CYCLES(MDU_CYCLES), .CNT_W(CNT_W)) u_mdu (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .start_i     (ex_mdu_start_i),
    .mem_wait_i  (mem_wait),
    .mdu_stall_o (mdu_stall),
    .busy_o      (mdu_busy_o),
    .done_o      (mdu_done_o)
  );
  assign stall_o = live ? merge_stall(mem_wait, mdu_stall, id_loaduse_i) : '0;
`ifdef STALL_PERF_CNT_EN
  logic [PERF_W-1:0] lu_q, lu_d, mdu_q, mdu_d, mem_q, mem_d;
  logic win_lu, win_mdu, win_mem;
  always_comb begin
    win_mem = live && mem_wait;
    win_mdu = live && !mem_wait && mdu_stall;
    win_lu  = live && !mem_wait && !mdu_stall && id_loaduse_i;
    lu_d    = (win_lu && !(&lu_q)) ? lu_q + PERF_W'(1) : lu_q;
    mdu_d   = (win_mdu && !(&mdu_q)) ? mdu_q + PERF_W'(1) : mdu_q;
    mem_d   = (win_mem && !(&mem_q)) ? mem_q + PERF_W'(1) : mem_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_q  <= '0;
      mdu_q <= '0;
      mem_q <= '0;
    end else begin
      lu_q  <= lu_d;
      mdu_q <= mdu_d;
      mem_q <= mem_d;
    end
  end
  assign perf_lu_o  = lu_q;
  assign perf_mdu_o = mdu_q;
  assign perf_mem_o = mem_q;
`else
  assign perf_lu_o  = '0;
  assign perf_mdu_o = '0;
  assign perf_mem_o = '0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed checks of stall merging, MDU sequencing, flush and async reset.
`timescale 1ns/1ps
module tb_pipe_stall_ctrl;
`ifdef STALL_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif
  logic clk, rst, flush_i, id_loaduse_i, ex_mdu_start_i, mem_req_i, mem_ack_i;
  logic [5:0] stall_o;
  logic mdu_busy_o, mdu_done_o;
  logic [31:0] perf_lu_o, perf_mdu_o, perf_mem_o;
  int total = 0, bad = 0;
  int e_lu = 0, e_mdu = 0, e_mem = 0;
  int dones, busys;
  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .id_loaduse_i(id_loaduse_i),
    .ex_mdu_start_i(ex_mdu_start_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .mdu_busy_o(mdu_busy_o), .mdu_done_o(mdu_done_o),
    .perf_lu_o(perf_lu_o), .perf_mdu_o(perf_mdu_o), .perf_mem_o(perf_mem_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_perf(input string tag);
    chk({tag, "_perf_lu"}, perf_lu_o, PERF_EN ? 32'(e_lu) : 32'd0);
    chk({tag, "_perf_mdu"}, perf_mdu_o, PERF_EN ? 32'(e_mdu) : 32'd0);
    chk({tag, "_perf_mem"}, perf_mem_o, PERF_EN ? 32'(e_mem) : 32'd0);
  endtask
  initial begin
    rst = 1'b0; flush_i = 1'b0; id_loaduse_i = 1'b1; ex_mdu_start_i = 1'b1;
    mem_req_i = 1'b1; mem_ack_i = 1'b0;
    #1;
    chk("rst_stall", stall_o, 6'b0);
    chk("rst_busy", mdu_busy_o, 0);
    chk("rst_done", mdu_done_o, 0);
    chk_perf("rst");
    id_loaduse_i = 1'b0; ex_mdu_start_i = 1'b0; mem_req_i = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    chk("idle_stall", stall_o, 6'b0);
    // single load-use cycle
    @(negedge clk); id_loaduse_i = 1'b1; #1;
    chk("lu_stall", stall_o, 6'b000111);
    e_lu++;
    @(negedge clk); id_loaduse_i = 1'b0; #1;
    chk("lu_clear", stall_o, 6'b0);
    chk_perf("lu");
    // plain 32-cycle MDU op; start held through the done cycle is ignored
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); ex_mdu_start_i = 1'b1; #1;
      chk($sformatf("mdu_stall%0d", i), stall_o, 6'b001111);
      chk($sformatf("mdu_busy%0d", i), mdu_busy_o, (i != 0));
      e_mdu++;
    end
    @(negedge clk); #1;
    chk("mdu_done", mdu_done_o, 1);
    chk("mdu_done_stall", stall_o, 6'b0);
    chk("mdu_done_busy", mdu_busy_o, 0);
    @(negedge clk); ex_mdu_start_i = 1'b0; #1;
    chk("mdu_after_done", mdu_done_o, 0);
    chk("mdu_after_stall", stall_o, 6'b0);
    chk("mdu_after_busy", mdu_busy_o, 0);
    chk_perf("mdu");
    // MEM wait covering the last two BUSY cycles and two DONE cycles
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); ex_mdu_start_i = 1'b1; mem_req_i = (i >= 30); #1;
      chk($sformatf("ov_stall%0d", i), stall_o, (i >= 30) ? 6'b011111 : 6'b001111);
      if (i >= 30) e_mem++; else e_mdu++;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk($sformatf("ov_hold_stall%0d", i), stall_o, 6'b011111);
      chk($sformatf("ov_hold_done%0d", i), mdu_done_o, 1);
      e_mem++;
    end
    @(negedge clk); mem_ack_i = 1'b1; #1;
    chk("ov_ack_stall", stall_o, 6'b0);
    chk("ov_ack_done", mdu_done_o, 1);
    @(negedge clk); mem_req_i = 1'b0; mem_ack_i = 1'b0; ex_mdu_start_i = 1'b0; #1;
    chk("ov_idle_done", mdu_done_o, 0);
    chk("ov_idle_stall", stall_o, 6'b0);
    chk_perf("ov");
    // flush at BUSY cycle 10
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk); ex_mdu_start_i = 1'b1; flush_i = (i == 10); #1;
      chk($sformatf("fl_stall%0d", i), stall_o, (i == 10) ? 6'b0 : 6'b001111);
      if (i < 10) e_mdu++;
    end
    chk("fl_done_suppr", mdu_done_o, 0);
    @(negedge clk); flush_i = 1'b0; ex_mdu_start_i = 1'b0; #1;
    chk("fl_idle_busy", mdu_busy_o, 0);
    chk("fl_idle_stall", stall_o, 6'b0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (mdu_done_o) dones++;
    end
    chk("fl_no_done", dones, 0);
    chk_perf("fl");
    // async reset in the middle of BUSY
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ex_mdu_start_i = 1'b1;
    end
    @(negedge clk); #1;
    chk("ar_pre_busy", mdu_busy_o, 1);
    rst = 1'b0; #1;
    e_lu = 0; e_mdu = 0; e_mem = 0;
    chk("ar_stall", stall_o, 6'b0);
    chk("ar_busy", mdu_busy_o, 0);
    chk_perf("ar");
    ex_mdu_start_i = 1'b0; #1; rst = 1'b1;
    dones = 0; busys = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (mdu_done_o) dones++;
      if (mdu_busy_o || stall_o != 6'b0) busys++;
    end
    chk("ar_no_done", dones, 0);
    chk("ar_stays_idle", busys, 0);
    // load-use and MDU together: MDU wins, load-use shows once MDU is done
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); ex_mdu_start_i = 1'b1; id_loaduse_i = 1'b1; #1;
      chk($sformatf("both_stall%0d", i), stall_o, 6'b001111);
      e_mdu++;
    end
    @(negedge clk); #1;
    chk("both_done", mdu_done_o, 1);
    chk("both_done_stall", stall_o, 6'b000111);
    e_lu++;
    @(negedge clk); ex_mdu_start_i = 1'b0; #1;
    chk("both_lu_stall", stall_o, 6'b000111);
    e_lu++;
    // ack without request, MEM priority over load-use, flush masking load-use
    @(negedge clk); id_loaduse_i = 1'b0; mem_ack_i = 1'b1; #1;
    chk("ack_noreq", stall_o, 6'b0);
    @(negedge clk); mem_ack_i = 1'b0; mem_req_i = 1'b1; id_loaduse_i = 1'b1; #1;
    chk("mem_over_lu", stall_o, 6'b011111);
    e_mem++;
    @(negedge clk); mem_req_i = 1'b0; flush_i = 1'b1; #1;
    chk("flush_lu", stall_o, 6'b0);
    @(negedge clk); flush_i = 1'b0; id_loaduse_i = 1'b0; #1;
    chk("end_stall", stall_o, 6'b0);
    chk_perf("end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline stall controller; the producer side of the 6-bit stall vector that every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb) consumes.
- Merges stage stall requests into one stall vector:
  - ID load-use hazard
  - EX multi-cycle multiply/divide
  - MEM data-bus wait
- Owns the MDU cycle counter/FSM.
- Sits beside the datapath in the top-level CPU.

Parameters:
- MDU_CYCLES, 32, total EX stall cycles per multi-cycle MDU op; legal 2..63.
- CNT_W, 6, width of the MDU down-counter.
- PERF_W, 32, width of each performance counter (optional feature only).

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-low reset
- flush_i  input  1  exception/ERET flush; aborts any MDU op, drops all stalls this cycle
- id_loaduse_i  input  1  ID source reg matches in-flight load destination
- ex_mdu_start_i  input  1  EX holds a multi-cycle MDU instruction (level, held while stalled)
- mem_req_i  input  1  MEM stage has an outstanding data-bus access
- mem_ack_i  input  1  data bus completes access this cycle
- stall_o  output  6  [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold stage
- mdu_busy_o  output  1  MDU FSM in BUSY
- mdu_done_o  output  1  result valid; EX may write back
- perf_lu_o  output  PERF_W  load-use stall cycles
- perf_mdu_o  output  PERF_W  MDU stall cycles
- perf_mem_o  output  PERF_W  MEM wait cycles

Behaviour:
- Reset: rst=0 asynchronously forces FSM=IDLE, cnt=0, perf counters=0. It also forces stall_o=0, mdu_busy_o=0, mdu_done_o=0 regardless of other inputs.
- stall_o is combinational from inputs and registered state; it is seen by pipeline registers at the same posedge.
- Request encodings:
  - load-use: 6'b000111. id_ex sees stall[2]=1, stall[3]=0 and inserts a bubble.
  - MDU: 6'b001111.
  - MEM wait (mem_req_i & ~mem_ack_i): 6'b011111.
- Priority: MEM wait > MDU > load-use. The output is the request of the highest-stalled stage.
- flush_i=1: stall_o=0 that cycle. Next state is IDLE, cnt=0, and mdu_done_o is suppressed.
- MDU FSM states: IDLE, BUSY, DONE.
  - IDLE & ex_mdu_start_i: assert MDU stall this cycle, cnt<=MDU_CYCLES-2, go to BUSY.
  - BUSY: assert MDU stall, mdu_busy_o=1, cnt decrements each cycle. When cnt==0, go to DONE.
  - The counter keeps counting while MEM wait stalls are active.
  - DONE: no MDU stall, mdu_done_o=1.
    - If a MEM wait is active (EX cannot advance), stay in DONE.
    - Otherwise go to IDLE next cycle.
  - ex_mdu_start_i seen in DONE is ignored; it belongs to the departing instruction.
  - Start-to-done latency is exactly MDU_CYCLES cycles with MDU stall, then the done cycle.
- mem_ack_i without mem_req_i is ignored.
- All counter arithmetic is unsigned, CNT_W bits. cnt never underflows because BUSY exits at 0.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - perf_lu_o, perf_mdu_o, perf_mem_o increment by 1 on each cycle in which their cause is the winning (highest-priority) stall source.
  - Counters saturate at all-ones.
  - Flush cycles are not counted.
- Undefined:
  - Counter logic is absent; the three ports are tied to 0.
  - The interface is unchanged.

Decomposition:
- Shared defines header holds:
  - stall vector width;
  - bit indices (STALL_PC..STALL_WB);
  - the three request encodings;
  - the MDU FSM state encodings.
- One sub-module: mdu_cycle_fsm, containing the IDLE/BUSY/DONE FSM and down-counter; outputs mdu_stall, busy and done.
- Priority merge and perf counters stay in pipe_stall_ctrl.

Test Plan:
- Async reset mid-BUSY: drop rst for half a cycle. Expected: stall_o=0, mdu_busy_o=0 immediately. After release, FSM is IDLE and no done pulse occurs.
- Load-use: id_loaduse_i=1 for one cycle. Expected: stall_o=6'b000111 that cycle only, and perf_lu_o increments by 1.
- MDU with MDU_CYCLES=32: hold ex_mdu_start_i. Expected: stall_o=6'b001111 for 32 cycles, then mdu_done_o=1 for 1 cycle with stall_o=0, then IDLE.
- MEM wait overlapping DONE: mem_req_i=1 and mem_ack_i=0 for 4 cycles, starting 2 cycles before the end of BUSY. Expected: stall_o=6'b011111 throughout. DONE is held until the mem_ack_i cycle, then returns to IDLE.
- Flush at BUSY cycle 10: expected stall_o=0 that cycle, IDLE next cycle, and no mdu_done_o pulse.
- Simultaneous id_loaduse_i and ex_mdu_start_i: expected stall_o=6'b001111. After MDU done, a persisting load-use gives 6'b000111.
